// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate-extension stage: mode codes and skid-buffer states.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package imm_ext_pkg;

  // Extension mode encoding carried on in_mode
  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // Skid-buffer occupancy: no word, main entry only, main and skid entries
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: SIGN / ZERO / UPPER / BRANCH (UPPER only with IMM_EXT_UPPER_EN).
// Latency: zero cycles, purely combinational.
// Backpressure: none, no handshake at this level.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32   // must be at least IN_W+2 so BRANCH keeps the full sign
) (
  input  logic [IN_W-1:0]  i_imm,
  input  logic [1:0]       i_mode,
  output logic [OUT_W-1:0] o_ext
);

  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_branch;

  assign w_sign   = {{E{i_imm[IN_W-1]}}, i_imm};
  assign w_zero   = {{E{1'b0}}, i_imm};
  // Two MSBs of the sign-extended value fall off the top
  assign w_branch = {w_sign[OUT_W-3:0], 2'b00};

`ifdef IMM_EXT_UPPER_EN
  // Immediate sits in the top IN_W bits; this equals x<<IN_W truncated to its top OUT_W bits
  logic [OUT_W-1:0] w_upper;
  assign w_upper = {i_imm, {E{1'b0}}};
`endif

  // Select the extension form requested by the mode
  always_comb begin
    o_ext = w_sign;
    case (i_mode)
      MODE_SIGN:   o_ext = w_sign;
      MODE_ZERO:   o_ext = w_zero;
`ifdef IMM_EXT_UPPER_EN
      MODE_UPPER:  o_ext = w_upper;
`else
      MODE_UPPER:  o_ext = w_zero;
`endif
      MODE_BRANCH: o_ext = w_branch;
      default:     o_ext = w_sign;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with two-entry skid buffer; IMM_EXT_UPPER_EN enables UPPER mode.
// Latency: one cycle from acceptance to out_valid; 1 word/cycle with out_ready held high.
// Backpressure: in_ready is a pure state decode, one stall cycle absorbed by the skid entry.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  logic [1:0]       r_state;
  logic [OUT_W-1:0] r_main_imm;
  logic [TAG_W-1:0] r_main_tag;
  logic [OUT_W-1:0] r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;

  logic [OUT_W-1:0] w_ext;
  logic             w_acc;
  logic             w_drn;

  // Extension is done at the input so only finished values are stored
  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm  (in_imm),
    .i_mode (in_mode),
    .o_ext  (w_ext)
  );

  // rst_n gating keeps upstream from handing us a word during reset
  assign in_ready  = rst_n & (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_imm   = r_main_imm;
  assign out_tag   = r_main_tag;

  assign w_acc = in_valid & in_ready;
  assign w_drn = out_valid & out_ready;

  // Occupancy state machine; flush empties the buffer regardless of handshakes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_acc) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_acc && !w_drn)      r_state <= ST_FULL;
          else if (!w_acc && w_drn) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_drn) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  // Entry storage; main always holds the oldest word so output order stays FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
    end else if (!flush) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main_imm <= w_ext;
            r_main_tag <= in_tag;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            r_main_imm <= w_ext;
            r_main_tag <= in_tag;
          end else if (w_acc) begin
            r_skid_imm <= w_ext;
            r_skid_tag <= in_tag;
          end
        end
        ST_FULL: begin
          if (w_drn) begin
            r_main_imm <= r_skid_imm;
            r_main_tag <= r_skid_tag;
          end
        end
        default: begin
          r_main_imm <= r_main_imm;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: mode sweep, backpressure, throughput, flush and reset.
// Latency: checks each word one cycle after acceptance.
// Backpressure: drives out_ready low to fill the skid entry and checks in_ready.
module tb_imm_ext_pipe;
  import imm_ext_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;
  int sent;
  logic acc;

  logic [4:0]  got_tag[$];
  logic [31:0] got_imm[$];

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word the consumer takes, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_tag.push_back(out_tag);
      got_imm.push_back(out_imm);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mode sweep vectors: imm, mode, tag, expected result
  logic [15:0] v_imm[7];
  logic [1:0]  v_mode[7];
  logic [31:0] v_exp[7];

  initial begin
    v_imm[0] = 16'h8001; v_mode[0] = MODE_SIGN;   v_exp[0] = 32'hFFFF8001;
    v_imm[1] = 16'h8001; v_mode[1] = MODE_ZERO;   v_exp[1] = 32'h00008001;
`ifdef IMM_EXT_UPPER_EN
    v_imm[2] = 16'h1234; v_mode[2] = MODE_UPPER;  v_exp[2] = 32'h12340000;
`else
    v_imm[2] = 16'h1234; v_mode[2] = MODE_UPPER;  v_exp[2] = 32'h00001234;
`endif
    v_imm[3] = 16'hFFFF; v_mode[3] = MODE_BRANCH; v_exp[3] = 32'hFFFFFFFC;
    v_imm[4] = 16'h7FFF; v_mode[4] = MODE_BRANCH; v_exp[4] = 32'h0001FFFC;
    v_imm[5] = 16'h8001; v_mode[5] = MODE_BRANCH; v_exp[5] = 32'hFFFE0004;
    v_imm[6] = 16'h0004; v_mode[6] = MODE_SIGN;   v_exp[6] = 32'h00000004;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0;
    in_mode = MODE_SIGN; in_tag = '0; out_ready = 1'b1;

    // Reset state
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // Mode sweep, one word at a time, out_ready high
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_imm = v_imm[i]; in_mode = v_mode[i]; in_tag = 5'(i + 1);
      step();
      in_valid = 1'b0;
      chk($sformatf("mode%0d_valid", i), out_valid, 1);
      chk($sformatf("mode%0d_imm", i), out_imm, v_exp[i]);
      chk($sformatf("mode%0d_tag", i), out_tag, 32'(i + 1));
      step();
      chk($sformatf("mode%0d_drained", i), out_valid, 0);
    end

    // Backpressure: tags 1..6, out_ready low for 3 cycles after the first word
    got_tag.delete(); got_imm.delete();
    sent = 0;
    for (int c = 0; c < 40 && got_tag.size() < 6; c++) begin
      in_valid  = (sent < 6);
      in_tag    = 5'(sent + 1);
      in_imm    = 16'(sent + 1);
      in_mode   = MODE_ZERO;
      out_ready = !(c >= 1 && c <= 3);
      if (c == 1) chk("bp_rdy_one_stall", in_ready, 1);
      if (c == 2) chk("bp_rdy_full", in_ready, 0);
      if (c == 4) chk("bp_rdy_full_drain", in_ready, 0);
      if (c == 5) chk("bp_rdy_reopen", in_ready, 1);
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got_tag.size(), 6);
    for (int i = 0; i < 6 && i < got_tag.size(); i++) begin
      chk($sformatf("bp_tag%0d", i), got_tag[i], 32'(i + 1));
      chk($sformatf("bp_imm%0d", i), got_imm[i], 32'(i + 1));
    end

    // Simultaneous accept and drain held in ONE
    step();
    got_tag.delete(); got_imm.delete();
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_tag = 5'(8 + i); in_imm = 16'(8 + i); in_mode = MODE_SIGN;
      if (i > 0) begin
        chk($sformatf("thru_rdy%0d", i), in_ready, 1);
        chk($sformatf("thru_vld%0d", i), out_valid, 1);
        chk($sformatf("thru_tag%0d", i), out_tag, 32'(8 + i - 1));
      end
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("thru_count", got_tag.size(), 11);
    if (got_tag.size() > 0) chk("thru_last", got_tag[got_tag.size() - 1], 18);

    // Flush while FULL with a word offered
    got_tag.delete(); got_imm.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd20; in_imm = 16'h0020; step();
    in_tag = 5'd21; in_imm = 16'h0021; step();
    chk("fl_full", in_ready, 0);
    flush = 1'b1; in_tag = 5'd22; in_imm = 16'h0022;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step(); step(); step();
    chk("fl_nothing_out", got_tag.size(), 0);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd25; in_imm = 16'hABCD; in_mode = MODE_SIGN; step();
    in_tag = 5'd26; in_imm = 16'h1111; step();
    in_valid = 1'b0;
    chk("rf_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rf_rdy_in_reset", in_ready, 0);
    step();
    chk("rf_out_valid", out_valid, 0);
    chk("rf_out_imm", out_imm, 0);
    chk("rf_out_tag", out_tag, 0);
    chk("rf_rdy_held", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rf_rdy_after", in_ready, 1);
    step(); step();
    chk("rf_nothing_out", got_tag.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension stage for the MIPS datapath. Accepts an IN_W-bit immediate plus a mode (sign-extend, zero-extend, upper-load, branch-offset) over a valid/ready handshake. Delivers the OUT_W-bit result one cycle later through a two-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`. Sits between decode and the ALU-operand mux and replaces the purely combinational 16→32 sign extension.

## Interface
- `IN_W`, 16, immediate input width.
- `OUT_W`, 32, extended output width; must satisfy OUT_W ≥ IN_W+2.
- `TAG_W`, 5, width of the sideband tag (destination register / ROB id) carried alongside.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — reset is synchronous and active-low.
- `flush` input 1 — synchronous pipeline flush, discards all held entries.
- `in_valid` input 1 — input word present.
- `in_ready` output 1 — stage can accept this cycle.
- `in_imm` input IN_W — raw immediate.
- `in_mode` input 2 — 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH.
- `in_tag` input TAG_W — sideband, passed through unchanged.
- `out_valid` output 1 — result present.
- `out_ready` input 1 — consumer accepts.
- `out_imm` output OUT_W — extended immediate.
- `out_tag` output TAG_W — tag of the result.

## Operation
- Extension, with x = in_imm and E = OUT_W-IN_W:
  - SIGN: {E{x[IN_W-1]}, x}.
  - ZERO: {E{0}, x}.
  - UPPER: x placed at the top of the word with zero low bits; for 16/32 this is `x<<16`. When OUT_W < 2·IN_W, the top IN_W bits of the low-filled value are used.
  - BRANCH: SIGN result shifted left 2; the two MSBs shifted out are discarded.
- The result is computed at acceptance and stored. `out_imm` comes from a register, never from `in_imm` directly.
- The buffer has two entries (main, skid). State is EMPTY, ONE or FULL.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- State transitions:
  - EMPTY: accept → ONE.
  - ONE: accept without drain → FULL (new word to skid); drain without accept → EMPTY; both → ONE (new word to main).
  - FULL: drain → ONE (skid moves to main); no accept possible.
- Output port decode:
  - `in_ready` = state≠FULL, forced 0 while rst_n=0.
  - `out_valid` = state≠EMPTY.
- Ordering is strict FIFO; `out_imm`/`out_tag` stay stable while out_valid=1 and out_ready=0.
- Flush: next state EMPTY. A simultaneous accept is dropped and a simultaneous drain still counts as consumed. Flush has priority over everything except reset.
- Reset (rst_n=0 at a rising edge): state EMPTY, out_valid 0, out_imm 0, out_tag 0, skid contents 0. Reset mid-transfer discards held words with no partial output.

## Timing
- Latency: a word accepted at edge N is visible on `out_*` after edge N; it can be consumed at edge N+1.
- Throughput is 1 word/cycle with out_ready held high.
- A single out_ready=0 cycle is absorbed by the skid entry without dropping `in_ready` that cycle. `in_ready` falls on the edge the state becomes FULL.
- After `out_ready` rises in FULL, `in_ready` is 1 the following cycle.
- `in_ready`, `out_valid`, `out_imm` and `out_tag` are all register outputs or pure state decodes, with no input→output combinational paths.

## Configuration
- `IMM_EXT_UPPER_EN` defined: UPPER mode operates as described.
- Undefined: mode 10 decodes as ZERO, and the UPPER shifter is not synthesised. All other behaviour is unchanged.

## Structure
- The shared package `imm_ext_pkg` holds:
  - the mode encoding constants (MODE_SIGN=2'b00, MODE_ZERO=2'b01, MODE_UPPER=2'b10, MODE_BRANCH=2'b11);
  - the buffer state encoding (EMPTY, ONE, FULL).
- One sub-module, `imm_ext_core`: purely combinational, parametrised IN_W/OUT_W, mode in, extended value out. It is instantiated once at the input side. The top module holds the handshake state machine and the two registers.

## Test plan
- Mode sweep with IN_W=16, OUT_W=32, out_ready=1:
  - 0x8001 SIGN → 0xFFFF8001
  - 0x8001 ZERO → 0x00008001
  - 0x1234 UPPER → 0x12340000
  - 0xFFFF BRANCH → 0xFFFFFFFC
  - Each appears one cycle after acceptance, with its tag.
- Backpressure: stream tags 1..6 with out_ready=0 for 3 cycles after the first word.
  - in_ready drops after the 2nd held word.
  - The output order is exactly 1..6 with none lost or duplicated.
- Simultaneous accept+drain in ONE for 10 cycles: state stays ONE, in_ready stays 1, one word out per cycle.
- Flush with FULL and in_valid=1 in the same cycle: the next cycle has out_valid=0 and in_ready=1, and the flushed or dropped words never appear.
- Reset asserted while FULL, held 1 cycle: out_valid=0, out_imm=0, out_tag=0, in_ready=0 during reset and 1 after.
- Build without IMM_EXT_UPPER_EN: 0x1234 with mode 10 → 0x00001234.
